// File: rtl/rdma_xmit_arbiter.sv
// rdma_xmit_arbiter
// Two-requester round-robin arbiter. Arbitration happens once per burst, so one
// requester's {address beat, data burst} pair reaches the shared RDMA transmit
// path without interleaving. All stream signals are combinational muxes that
// follow the registered grant. The block holds no data registers.
//
// Optional build macro: ARB_STATS_EN
//   Adds burst_count0 / burst_count1, which are 32-bit wrapping counts of
//   completed bursts (TLAST handshakes) per requester.
module rdma_xmit_arbiter #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    resetn,

  input  logic [ADDR_WIDTH-1:0]   S0_AXIS_ADDR_TDATA,
  input  logic                    S0_AXIS_ADDR_TVALID,
  output logic                    S0_AXIS_ADDR_TREADY,
  input  logic [DATA_WIDTH-1:0]   S0_AXIS_DATA_TDATA,
  input  logic [DATA_WIDTH/8-1:0] S0_AXIS_DATA_TKEEP,
  input  logic                    S0_AXIS_DATA_TVALID,
  input  logic                    S0_AXIS_DATA_TLAST,
  output logic                    S0_AXIS_DATA_TREADY,

  input  logic [ADDR_WIDTH-1:0]   S1_AXIS_ADDR_TDATA,
  input  logic                    S1_AXIS_ADDR_TVALID,
  output logic                    S1_AXIS_ADDR_TREADY,
  input  logic [DATA_WIDTH-1:0]   S1_AXIS_DATA_TDATA,
  input  logic [DATA_WIDTH/8-1:0] S1_AXIS_DATA_TKEEP,
  input  logic                    S1_AXIS_DATA_TVALID,
  input  logic                    S1_AXIS_DATA_TLAST,
  output logic                    S1_AXIS_DATA_TREADY,

  output logic [ADDR_WIDTH-1:0]   M_AXIS_ADDR_TDATA,
  output logic                    M_AXIS_ADDR_TVALID,
  input  logic                    M_AXIS_ADDR_TREADY,
  output logic [DATA_WIDTH-1:0]   M_AXIS_DATA_TDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXIS_DATA_TKEEP,
  output logic                    M_AXIS_DATA_TVALID,
  output logic                    M_AXIS_DATA_TLAST,
  input  logic                    M_AXIS_DATA_TREADY,

`ifdef ARB_STATS_EN
  output logic [31:0]             burst_count0,
  output logic [31:0]             burst_count1,
`endif
  output logic [1:0]              grant
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_ADDR = 2'd1,
    SEND_DATA = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_grant_q, last_grant_d;   // index of the last requester served

  logic       addr_phase;
  logic       data_phase;
  logic       addr_hs;
  logic       data_last_hs;

  // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
  function automatic logic [1:0] pick_grant(input logic [1:0] req, input logic last_idx);
    logic [1:0] g;
    g = 2'b00;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last_idx ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

  assign addr_phase = (state_q == SEND_ADDR);
  assign data_phase = (state_q == SEND_DATA);
  assign addr_hs      = M_AXIS_ADDR_TVALID && M_AXIS_ADDR_TREADY;
  assign data_last_hs = M_AXIS_DATA_TVALID && M_AXIS_DATA_TREADY && M_AXIS_DATA_TLAST;
  assign grant        = grant_q;

  // Control registers: state, owner and round-robin history.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, move on address handshake, release on TLAST.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        grant_d = pick_grant({S1_AXIS_ADDR_TVALID, S0_AXIS_ADDR_TVALID}, last_grant_q);
        if (grant_d != 2'b00) state_d = SEND_ADDR;
      end
      SEND_ADDR: begin
        if (addr_hs) state_d = SEND_DATA;
      end
      SEND_DATA: begin
        if (data_last_hs) begin
          state_d      = IDLE;
          grant_d      = 2'b00;
          last_grant_d = grant_q[1];
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Stream muxing: the grant selects the source, the state selects the channel.
  // With grant == 00 (idle or in reset) every valid and ready is forced low.
  always_comb begin
    M_AXIS_ADDR_TDATA   = grant_q[1] ? S1_AXIS_ADDR_TDATA : S0_AXIS_ADDR_TDATA;
    M_AXIS_DATA_TDATA   = grant_q[1] ? S1_AXIS_DATA_TDATA : S0_AXIS_DATA_TDATA;
    M_AXIS_DATA_TKEEP   = grant_q[1] ? S1_AXIS_DATA_TKEEP : S0_AXIS_DATA_TKEEP;
    M_AXIS_DATA_TLAST   = grant_q[1] ? S1_AXIS_DATA_TLAST : S0_AXIS_DATA_TLAST;

    M_AXIS_ADDR_TVALID  = addr_phase && ((grant_q[0] && S0_AXIS_ADDR_TVALID) ||
                                         (grant_q[1] && S1_AXIS_ADDR_TVALID));
    M_AXIS_DATA_TVALID  = data_phase && ((grant_q[0] && S0_AXIS_DATA_TVALID) ||
                                         (grant_q[1] && S1_AXIS_DATA_TVALID));

    S0_AXIS_ADDR_TREADY = addr_phase && grant_q[0] && M_AXIS_ADDR_TREADY;
    S1_AXIS_ADDR_TREADY = addr_phase && grant_q[1] && M_AXIS_ADDR_TREADY;
    S0_AXIS_DATA_TREADY = data_phase && grant_q[0] && M_AXIS_DATA_TREADY;
    S1_AXIS_DATA_TREADY = data_phase && grant_q[1] && M_AXIS_DATA_TREADY;
  end

`ifdef ARB_STATS_EN
  logic [31:0] burst_cnt0_q;
  logic [31:0] burst_cnt1_q;

  // Completed-burst counters, one per requester, wrapping at 2^32.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      burst_cnt0_q <= 32'd0;
      burst_cnt1_q <= 32'd0;
    end else if (data_phase && data_last_hs) begin
      if (grant_q[0]) burst_cnt0_q <= burst_cnt0_q + 32'd1;
      if (grant_q[1]) burst_cnt1_q <= burst_cnt1_q + 32'd1;
    end
  end

  assign burst_count0 = burst_cnt0_q;
  assign burst_count1 = burst_cnt1_q;
`endif

endmodule

// File: tb/tb_rdma_xmit_arbiter.sv
// Testbench for rdma_xmit_arbiter: per-requester burst drivers, a scoreboard
// of expected {owner, address} and {owner, beat} entries, and a negedge monitor.
module tb_rdma_xmit_arbiter;
  localparam int DW  = 64;
  localparam int AW  = 32;
  localparam int KW  = DW / 8;
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][AW-1:0] s_atdata;
  logic [1:0]         s_avalid;
  logic [1:0]         s_aready;
  logic [1:0][DW-1:0] s_dtdata;
  logic [1:0][KW-1:0] s_dkeep;
  logic [1:0]         s_dvalid;
  logic [1:0]         s_dlast;
  logic [1:0]         s_dready;

  logic [AW-1:0] m_atdata;
  logic          m_avalid;
  logic          m_aready;
  logic [DW-1:0] m_dtdata;
  logic [KW-1:0] m_dkeep;
  logic          m_dvalid;
  logic          m_dlast;
  logic          m_dready;
  logic [1:0]    grant;
`ifdef ARB_STATS_EN
  logic [31:0]   burst_count0;
  logic [31:0]   burst_count1;
`endif

  rdma_xmit_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .S0_AXIS_ADDR_TDATA  (s_atdata[0]),
    .S0_AXIS_ADDR_TVALID (s_avalid[0]),
    .S0_AXIS_ADDR_TREADY (s_aready[0]),
    .S0_AXIS_DATA_TDATA  (s_dtdata[0]),
    .S0_AXIS_DATA_TKEEP  (s_dkeep[0]),
    .S0_AXIS_DATA_TVALID (s_dvalid[0]),
    .S0_AXIS_DATA_TLAST  (s_dlast[0]),
    .S0_AXIS_DATA_TREADY (s_dready[0]),
    .S1_AXIS_ADDR_TDATA  (s_atdata[1]),
    .S1_AXIS_ADDR_TVALID (s_avalid[1]),
    .S1_AXIS_ADDR_TREADY (s_aready[1]),
    .S1_AXIS_DATA_TDATA  (s_dtdata[1]),
    .S1_AXIS_DATA_TKEEP  (s_dkeep[1]),
    .S1_AXIS_DATA_TVALID (s_dvalid[1]),
    .S1_AXIS_DATA_TLAST  (s_dlast[1]),
    .S1_AXIS_DATA_TREADY (s_dready[1]),
    .M_AXIS_ADDR_TDATA   (m_atdata),
    .M_AXIS_ADDR_TVALID  (m_avalid),
    .M_AXIS_ADDR_TREADY  (m_aready),
    .M_AXIS_DATA_TDATA   (m_dtdata),
    .M_AXIS_DATA_TKEEP   (m_dkeep),
    .M_AXIS_DATA_TVALID  (m_dvalid),
    .M_AXIS_DATA_TLAST   (m_dlast),
    .M_AXIS_DATA_TREADY  (m_dready),
`ifdef ARB_STATS_EN
    .burst_count0        (burst_count0),
    .burst_count1        (burst_count1),
`endif
    .grant               (grant)
  );

  typedef struct packed {
    logic [1:0]    g;
    logic [AW-1:0] a;
  } aexp_t;

  typedef struct packed {
    logic [1:0]    g;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } dexp_t;

  aexp_t exp_a[$];
  dexp_t exp_d[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tlast_cyc = 0;
  int dhs_cnt = 0;
  bit chk_gap = 1'b0;
  bit abort = 1'b0;
  bit tog_en = 1'b0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a, input int b);
    return {a, 32'(b)};
  endfunction

  function automatic logic [KW-1:0] beat_keep(input int b);
    logic [KW-1:0] k;
    k = '1;
    return k >> (b % 4);
  endfunction

  // Scoreboard push: one address entry plus n beats, owned by requester r.
  task automatic exp_burst(input int r, input logic [AW-1:0] a, input int n);
    aexp_t ea;
    dexp_t ed;
    ea.g = (r == 0) ? 2'b01 : 2'b10;
    ea.a = a;
    exp_a.push_back(ea);
    for (int b = 0; b < n; b++) begin
      ed.g = ea.g;
      ed.d = beat_data(a, b);
      ed.k = beat_keep(b);
      ed.l = (b == n - 1);
      exp_d.push_back(ed);
    end
  endtask

  // Requester model: address beat first, then the data beats; drives at posedge+1.
  task automatic drive_burst(input int r, input logic [AW-1:0] a, input int n);
    int t;
    bit hs;
    s_atdata[r] = a;
    s_avalid[r] = 1'b1;
    t = 0;
    hs = 1'b0;
    do begin
      @(negedge clk);
      hs = s_aready[r];
      @(posedge clk);
      #1;
      t++;
    end while (!hs && !abort && t < TMO);
    s_avalid[r] = 1'b0;
    if (!hs && !abort) chk("addr_timeout", hs, 1'b1);
    for (int b = 0; b < n && hs && !abort; b++) begin
      s_dtdata[r] = beat_data(a, b);
      s_dkeep[r]  = beat_keep(b);
      s_dlast[r]  = (b == n - 1);
      s_dvalid[r] = 1'b1;
      t = 0;
      hs = 1'b0;
      do begin
        @(negedge clk);
        hs = s_dready[r];
        @(posedge clk);
        #1;
        t++;
      end while (!hs && !abort && t < TMO);
      if (!hs && !abort) chk("data_timeout", hs, 1'b1);
    end
    s_dvalid[r] = 1'b0;
    s_dlast[r]  = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream data-ready toggler used during the stall scenario.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) m_dready = ~m_dready;
    end
  end

  // Output monitor: pops the scoreboard on each handshake and checks blocking rules.
  initial begin
    aexp_t ea;
    dexp_t ed;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (m_avalid && m_aready) begin
          if (exp_a.size() == 0) chk("addr_unexpected", exp_a.size(), 1);
          else begin
            ea = exp_a.pop_front();
            chk("addr_value", m_atdata, ea.a);
            chk("addr_grant", grant, ea.g);
            if (chk_gap) chk("idle_gap", cyc - tlast_cyc, 2);
          end
        end
        if (m_dvalid && m_dready) begin
          dhs_cnt++;
          if (exp_d.size() == 0) chk("data_unexpected", exp_d.size(), 1);
          else begin
            ed = exp_d.pop_front();
            chk("data_value", m_dtdata, ed.d);
            chk("data_keep", m_dkeep, ed.k);
            chk("data_last", m_dlast, ed.l);
            chk("data_grant", grant, ed.g);
          end
          if (m_dlast) tlast_cyc = cyc;
        end
        if (!grant[0]) chk("s0_blocked", {s_aready[0], s_dready[0]}, 2'b00);
        if (!grant[1]) chk("s1_blocked", {s_aready[1], s_dready[1]}, 2'b00);
        if (m_avalid) chk("addr_data_excl", m_dvalid, 1'b0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int t;
    int base;
    s_atdata = '0; s_avalid = '0; s_dtdata = '0; s_dkeep = '0;
    s_dvalid = '0; s_dlast = '0;
    m_aready = 1'b1;
    m_dready = 1'b1;

    // Reset state, with requests and downstream ready already asserted.
    s_avalid = 2'b11;
    s_dvalid = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_m_valid", {m_avalid, m_dvalid}, 2'b00);
    chk("rst_s_ready", {s_aready, s_dready}, 4'b0000);
    s_avalid = 2'b00;
    s_dvalid = 2'b00;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Simultaneous requests: S0 first, then S1; ten cycles end to end.
    exp_burst(0, 32'h1000, 4);
    exp_burst(1, 32'h2000, 2);
    t0 = cyc;
    fork
      drive_burst(0, 32'h1000, 4);
      drive_burst(1, 32'h2000, 2);
    join
    chk("tie_total_cycles", tlast_cyc - t0 + 1, 10);

    // S0 alone, back to back: one idle cycle between bursts.
    for (int i = 0; i < 3; i++) begin
      exp_burst(0, 32'h3000 + 32'(i * 16), 2);
      drive_burst(0, 32'h3000 + 32'(i * 16), 2);
      @(negedge clk);
      chk("b2b_idle_grant", grant, 2'b00);
      chk_gap = 1'b1;
    end
    chk_gap = 1'b0;

    // S1 burst with toggling downstream ready; S0 requests mid-burst.
    exp_burst(1, 32'h4000, 3);
    exp_burst(0, 32'h4100, 2);
    tog_en = 1'b1;
    fork
      drive_burst(1, 32'h4000, 3);
      begin
        repeat (3) @(posedge clk);
        #1;
        drive_burst(0, 32'h4100, 2);
      end
    join
    tog_en = 1'b0;
    m_dready = 1'b1;

    // Single-beat bursts from both requesters after reset: strict alternation.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_burst(0, 32'h5000 + 32'(i * 16), 1);
      exp_burst(1, 32'h5800 + 32'(i * 16), 1);
    end
    fork
      for (int i = 0; i < 4; i++) drive_burst(0, 32'h5000 + 32'(i * 16), 1);
      for (int j = 0; j < 4; j++) drive_burst(1, 32'h5800 + 32'(j * 16), 1);
    join
`ifdef ARB_STATS_EN
    @(negedge clk);
    chk("stats_cnt0", burst_count0, 32'd4);
    chk("stats_cnt1", burst_count1, 32'd4);
`endif

    // Reset during beat 2 of a 4-beat burst.
    exp_burst(0, 32'h6000, 4);
    base = dhs_cnt;
    fork
      drive_burst(0, 32'h6000, 4);
    join_none
    t = 0;
    while (dhs_cnt < base + 1 && t < TMO) begin
      @(posedge clk);
      t++;
    end
    chk("midrst_first_beat", dhs_cnt, base + 1);
    #2;
    chk("midrst_pre_ready", s_dready[0], 1'b1);
    resetn = 1'b0;
    #1;
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_m_valid", {m_avalid, m_dvalid}, 2'b00);
    chk("midrst_s_ready", {s_aready, s_dready}, 4'b0000);
    abort = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b0;
    exp_a.delete();
    exp_d.delete();
    s_avalid = '0; s_dvalid = '0; s_dlast = '0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    exp_burst(0, 32'h7000, 1);
    exp_burst(1, 32'h8000, 1);
    fork
      drive_burst(0, 32'h7000, 1);
      drive_burst(1, 32'h8000, 1);
    join

`ifdef ARB_STATS_EN
    // Counter wrap from all-ones.
    do_reset();
    @(negedge clk);
    force dut.burst_cnt0_q = 32'hFFFF_FFFF;
    #1;
    release dut.burst_cnt0_q;
    @(posedge clk);
    #1;
    chk("stats_preload", burst_count0, 32'hFFFF_FFFF);
    exp_burst(0, 32'h9000, 2);
    drive_burst(0, 32'h9000, 2);
    @(negedge clk);
    chk("stats_wrap", burst_count0, 32'd0);
    chk("stats_other", burst_count1, 32'd0);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_addr_drained", exp_a.size(), 0);
    chk("sb_data_drained", exp_d.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
